// File: rtl/can_pkg.sv
// Shared CAN bit-level constants used by the transmit stuffer and the receive stuff checker.
package can_pkg;

   localparam logic RECESSIVE         = 1'b1;
   localparam logic DOMINANT          = 1'b0;
   localparam int   DEFAULT_STUFF_RUN = 5;

endpackage

// File: rtl/can_bit_stuffer_if.sv
// Unstuffed bit hand-off between the frame serializer (master) and the bit stuffer (slave).
interface can_bit_stuffer_if;

   logic in_bit;
   logic in_valid;
   logic in_ready;

   modport master (output in_bit, output in_valid, input in_ready);
   modport slave  (input in_bit, input in_valid, output in_ready);

endinterface

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: inserts a complementary bit after STUFF_RUN identical bits.
// Optional CAN_STUFF_ERR_INJECT_EN adds force_stuff_err to emit a deliberately wrong stuff bit.
module can_bit_stuffer
   import can_pkg::*;
#(
   parameter int STUFF_RUN = DEFAULT_STUFF_RUN,
   parameter int CNT_W     = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bit_tick,
   input  logic              stuff_en,
   can_bit_stuffer_if.slave  in_if,
`ifdef CAN_STUFF_ERR_INJECT_EN
   input  logic              force_stuff_err,
`endif
   output logic              tx_out,
   output logic              stuff_inserted,
   output logic              underrun,
   output logic [CNT_W-1:0]  stuff_count
);

   // One extra count value lets an injected error run saturate above STUFF_RUN.
   localparam int RUN_W = $clog2(STUFF_RUN + 2);
   localparam logic [RUN_W-1:0] RUN_ZERO  = {RUN_W{1'b0}};
   localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_STUFF = RUN_W'(STUFF_RUN);
   localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(STUFF_RUN + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   logic             last_bit_r, last_bit_s;
   logic [RUN_W-1:0] run_cnt_r, run_cnt_s;
   logic             stuff_pending_r, stuff_pending_s;
   logic [CNT_W-1:0] stuff_count_r, stuff_count_s;
   logic             stuff_en_d_r, stuff_en_d_s;
   logic             tx_out_r, tx_out_s;
   logic             stuff_inserted_r, stuff_inserted_s;
   logic             underrun_r, underrun_s;
   logic             data_bit_s;
   logic             force_err_s;

`ifdef CAN_STUFF_ERR_INJECT_EN
   assign force_err_s = force_stuff_err;
`else
   assign force_err_s = 1'b0;
`endif

   assign in_if.in_ready = bit_tick & ~stuff_pending_r;

   // Next-state logic: all state advances only on bit_tick.
   always_comb begin
      last_bit_s       = last_bit_r;
      run_cnt_s        = run_cnt_r;
      stuff_pending_s  = stuff_pending_r;
      stuff_count_s    = stuff_count_r;
      stuff_en_d_s     = stuff_en_d_r;
      tx_out_s         = tx_out_r;
      stuff_inserted_s = 1'b0;
      underrun_s       = 1'b0;
      data_bit_s       = RECESSIVE;
      if (bit_tick) begin
         stuff_en_d_s = stuff_en;
         if (stuff_en && !stuff_en_d_r) begin
            stuff_count_s = CNT_ZERO;
         end else begin
            stuff_count_s = stuff_count_r;
         end
         if (stuff_pending_r) begin
            // Stuff bit counts as the first bit of the next run unless it is forced wrong.
            if (force_err_s) begin
               tx_out_s  = last_bit_r;
               run_cnt_s = RUN_SAT;
            end else begin
               tx_out_s  = ~last_bit_r;
               run_cnt_s = RUN_ONE;
            end
            last_bit_s       = tx_out_s;
            stuff_pending_s  = 1'b0;
            stuff_inserted_s = 1'b1;
            if (stuff_count_r != CNT_MAX) begin
               stuff_count_s = stuff_count_r + CNT_W'(1);
            end else begin
               stuff_count_s = stuff_count_r;
            end
         end else begin
            if (in_if.in_valid) begin
               data_bit_s = in_if.in_bit;
            end else begin
               data_bit_s = RECESSIVE;
               underrun_s = 1'b1;
            end
            tx_out_s   = data_bit_s;
            last_bit_s = data_bit_s;
            if (!stuff_en) begin
               run_cnt_s = RUN_ZERO;
            end else if (run_cnt_r == RUN_ZERO || data_bit_s != last_bit_r) begin
               run_cnt_s = RUN_ONE;
            end else if (run_cnt_r == RUN_SAT) begin
               run_cnt_s = RUN_SAT;
            end else begin
               run_cnt_s = run_cnt_r + RUN_ONE;
            end
            stuff_pending_s = stuff_en && (run_cnt_s == RUN_STUFF);
         end
      end else begin
         stuff_en_d_s = stuff_en_d_r;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_bit_r       <= RECESSIVE;
         run_cnt_r        <= RUN_ZERO;
         stuff_pending_r  <= 1'b0;
         stuff_count_r    <= CNT_ZERO;
         stuff_en_d_r     <= 1'b0;
         tx_out_r         <= RECESSIVE;
         stuff_inserted_r <= 1'b0;
         underrun_r       <= 1'b0;
      end else begin
         last_bit_r       <= last_bit_s;
         run_cnt_r        <= run_cnt_s;
         stuff_pending_r  <= stuff_pending_s;
         stuff_count_r    <= stuff_count_s;
         stuff_en_d_r     <= stuff_en_d_s;
         tx_out_r         <= tx_out_s;
         stuff_inserted_r <= stuff_inserted_s;
         underrun_r       <= underrun_s;
      end
   end

   assign tx_out         = tx_out_r;
   assign stuff_inserted = stuff_inserted_r;
   assign underrun       = underrun_r;
   assign stuff_count    = stuff_count_r;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed self-checking bench for can_bit_stuffer; per-tick expected tx/stuff/ready/underrun vectors.
module tb_can_bit_stuffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       bit_tick;
   logic       stuff_en;
   logic       force_stuff_err;
   logic       tx_out;
   logic       stuff_inserted;
   logic       underrun;
   logic [4:0] stuff_count;
   int         checks = 0;
   int         errors = 0;

   can_bit_stuffer_if bus ();

   can_bit_stuffer #(.STUFF_RUN(5), .CNT_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .bit_tick       (bit_tick),
      .stuff_en       (stuff_en),
      .in_if          (bus.slave),
`ifdef CAN_STUFF_ERR_INJECT_EN
      .force_stuff_err(force_stuff_err),
`endif
      .tx_out         (tx_out),
      .stuff_inserted (stuff_inserted),
      .underrun       (underrun),
      .stuff_count    (stuff_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One bit time: tick high for exactly one rising edge; ready sampled before, outputs #1 after.
   task automatic tick(input logic b, input logic v, input logic en, input logic frc,
                       output logic tx, output logic ins, output logic und, output logic rdy);
      @(negedge clk);
      bit_tick = 1'b1; bus.in_bit = b; bus.in_valid = v; stuff_en = en; force_stuff_err = frc;
      #1 rdy = bus.in_ready;
      @(posedge clk);
      #1;
      tx = tx_out; ins = stuff_inserted; und = underrun;
      bit_tick = 1'b0; bus.in_valid = 1'b0; force_stuff_err = 1'b0;
   endtask

   task automatic idle(input int n);
      logic tx, ins, und, rdy;
      for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, tx, ins, und, rdy);
   endtask

   task automatic test_reset();
      reset = 1'b1; bit_tick = 1'b1; bus.in_bit = 1'b0; bus.in_valid = 1'b1;
      stuff_en = 1'b1; force_stuff_err = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; bit_tick = 1'b0; bus.in_valid = 1'b0; stuff_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx_out); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
      checks++; if (stuff_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", stuff_count); end
      checks++; if (stuff_inserted !== 1'b0) begin errors++; $display("FAIL reset_stuff_pulse: got %b want 0", stuff_inserted); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
   endtask

   task automatic test_basic_stuff();
      logic [0:6] b   = 7'b0000011;
      logic [0:6] etx = 7'b0000011;
      logic [0:6] ein = 7'b0000010;
      logic [0:6] erd = 7'b1111101;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 7; i++) begin
         tick(b[i], 1'b1, 1'b1, 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {etx[i], ein[i], erd[i], 1'b0}) begin
            errors++;
            $display("FAIL basic_stuff tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {etx[i], ein[i], erd[i], 1'b0});
         end
      end
      checks++; if (stuff_count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", stuff_count); end
      idle(3);
      checks++; if (stuff_count !== 5'd1) begin errors++; $display("FAIL basic_count_hold: got %0d want 1", stuff_count); end
   endtask

   task automatic test_two_stuffs();
      logic [0:11] b   = 12'b111110000011;
      logic [0:11] etx = 12'b111110000011;
      logic [0:11] ein = 12'b000001000010;
      logic [0:11] erd = 12'b111110111101;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 12; i++) begin
         tick(b[i], 1'b1, 1'b1, 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {etx[i], ein[i], erd[i], 1'b0}) begin
            errors++;
            $display("FAIL two_stuffs tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {etx[i], ein[i], erd[i], 1'b0});
         end
      end
      checks++; if (stuff_count !== 5'd2) begin errors++; $display("FAIL two_stuffs_count: got %0d want 2", stuff_count); end
      idle(3);
   endtask

   task automatic test_stuff_en_edges();
      logic [0:6] b1  = 7'b0000011;
      logic [0:6] en1 = 7'b1111100;
      logic [0:6] ein = 7'b0000010;
      logic [0:6] erd = 7'b1111101;
      logic [0:5] en2 = 6'b111100;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 7; i++) begin
         tick(b1[i], 1'b1, en1[i], 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {b1[i], ein[i], erd[i], 1'b0}) begin
            errors++;
            $display("FAIL en_fall_after_5th tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {b1[i], ein[i], erd[i], 1'b0});
         end
      end
      checks++; if (stuff_count !== 5'd1) begin errors++; $display("FAIL en_fall_count: got %0d want 1", stuff_count); end
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, 1'b1, en2[i], 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== 4'b0010) begin
            errors++;
            $display("FAIL en_low_on_5th tick %0d: got tx/ins/rdy/und=%b want 0010", i, {tx, ins, rdy, und});
         end
      end
      checks++; if (stuff_count !== 5'd0) begin errors++; $display("FAIL en_low_count: got %0d want 0", stuff_count); end
      idle(2);
   endtask

   task automatic test_underrun();
      logic [0:6] b   = 7'b1111100;
      logic [0:6] v   = 7'b1111011;
      logic [0:6] etx = 7'b1111100;
      logic [0:6] ein = 7'b0000010;
      logic [0:6] erd = 7'b1111101;
      logic [0:6] eun = 7'b0000100;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 7; i++) begin
         tick(b[i] & v[i], v[i], 1'b1, 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {etx[i], ein[i], erd[i], eun[i]}) begin
            errors++;
            $display("FAIL underrun tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {etx[i], ein[i], erd[i], eun[i]});
         end
      end
      checks++; if (stuff_count !== 5'd1) begin errors++; $display("FAIL underrun_count: got %0d want 1", stuff_count); end
      idle(2);
   endtask

   task automatic test_reset_mid_frame();
      logic [0:5] ein = 6'b000001;
      logic [0:5] erd = 6'b111110;
      logic [0:5] etx = 6'b111110;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, tx, ins, und, rdy);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (tx_out !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx_out); end
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b0, tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {etx[i], ein[i], erd[i], 1'b0}) begin
            errors++;
            $display("FAIL midreset_run tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {etx[i], ein[i], erd[i], 1'b0});
         end
      end
      idle(2);
   endtask

   task automatic test_count_saturation();
      logic tx, ins, und, rdy;
      int   nins = 0;
      for (int i = 0; i < 240; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b0, tx, ins, und, rdy);
         if (ins === 1'b1) nins++;
      end
      checks++; if (nins !== 40) begin errors++; $display("FAIL sat_pulses: got %0d want 40", nins); end
      checks++; if (stuff_count !== 5'd31) begin errors++; $display("FAIL sat_count: got %0d want 31", stuff_count); end
      idle(2);
   endtask

`ifdef CAN_STUFF_ERR_INJECT_EN
   task automatic test_inject();
      logic [0:8] b   = 9'b000000001;
      logic [0:8] frc = 9'b000001000;
      logic [0:8] ein = 9'b000001000;
      logic [0:8] erd = 9'b111110111;
      logic tx, ins, und, rdy;
      for (int i = 0; i < 9; i++) begin
         tick(b[i], 1'b1, 1'b1, frc[i], tx, ins, und, rdy);
         checks++;
         if ({tx, ins, rdy, und} !== {b[i], ein[i], erd[i], 1'b0}) begin
            errors++;
            $display("FAIL inject tick %0d: got tx/ins/rdy/und=%b want %b", i, {tx, ins, rdy, und}, {b[i], ein[i], erd[i], 1'b0});
         end
      end
      checks++; if (stuff_count !== 5'd1) begin errors++; $display("FAIL inject_count: got %0d want 1", stuff_count); end
      idle(2);
   endtask
`endif

   initial begin
      test_reset();
      test_basic_stuff();
      test_two_stuffs();
      test_stuff_en_edges();
      test_underrun();
      test_reset_mid_frame();
      test_count_saturation();
`ifdef CAN_STUFF_ERR_INJECT_EN
      test_inject();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
